// File: rtl/mdu_pkg.sv
// Shared encodings, cycle defaults and divide helper for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_OP_NOP   = 4'd0,
        MDU_OP_MULT  = 4'd1,
        MDU_OP_MULTU = 4'd2,
        MDU_OP_DIV   = 4'd3,
        MDU_OP_DIVU  = 4'd4,
        MDU_OP_MTHI  = 4'd5,
        MDU_OP_MTLO  = 4'd6,
        MDU_OP_MFHI  = 4'd7,
        MDU_OP_MFLO  = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;
    localparam int MDU_CNT_W           = 16;

    // Returns {remainder, quotient}. Works on magnitudes so that
    // 0x80000000 / -1 wraps cleanly to 0x80000000 with remainder 0.
    // A zero divisor yields a don't-care result that the caller discards.
    function automatic logic [63:0] mdu_divide(input logic is_signed,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            mag_b = 32'd1;
        end
        quo = mag_a / mag_b;
        rem = mag_a % mag_b;
        if (neg_a ^ neg_b) begin
            quo = 32'd0 - quo;
        end
        if (neg_a) begin
            rem = 32'd0 - rem;
        end
        return {rem, quo};
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Operand/command bus between the execute stage and the multiply/divide unit.
interface mdu_if;
  logic [31:0] in_opA;
  logic [31:0] in_opB;
  logic [3:0]  in_option;
  logic        in_start;
  logic [31:0] out;
  logic        out_busy;

  modport master (output in_opA, output in_opB, output in_option, output in_start,
                  input  out,    input  out_busy);
  modport slave  (input  in_opA, input  in_opB, input  in_option, input  in_start,
                  output out,    output out_busy);
endinterface

// File: rtl/mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU into private HI/LO, plus MTHI/MTLO/MFHI/MFLO.
// Latency: HI/LO commit MULT_CYCLES or DIV_CYCLES edges after accept; MF* read is combinational.
// Backpressure: out_busy is high while running; any start presented while busy is dropped.
module mdu
    import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic in_clk,
  input  logic in_reset,
  mdu_if.slave bus
);

  mdu_state_e           state;
  logic [MDU_CNT_W-1:0] cnt;
  logic [31:0]          hi;
  logic [31:0]          lo;
  logic [31:0]          pend_hi;
  logic [31:0]          pend_lo;
  logic                 pend_wr;
  logic                 busy;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] div_s;
  logic [63:0] div_u;

  // Sign-extended operands give the correct low 64 bits of the signed product.
  assign prod_s = {{32{bus.in_opA[31]}}, bus.in_opA} * {{32{bus.in_opB[31]}}, bus.in_opB};
  assign prod_u = {32'd0, bus.in_opA} * {32'd0, bus.in_opB};
  assign div_s  = mdu_divide(1'b1, bus.in_opA, bus.in_opB);
  assign div_u  = mdu_divide(1'b0, bus.in_opA, bus.in_opB);

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_start) begin
            case (bus.in_option)
              MDU_OP_MULT, MDU_OP_MULTU: begin
                {pend_hi, pend_lo} <= (bus.in_option == MDU_OP_MULT) ? prod_s : prod_u;
                pend_wr <= 1'b1;
                cnt     <= MDU_CNT_W'(MULT_CYCLES);
                state   <= ST_MUL;
                busy    <= 1'b1;
              end
              MDU_OP_DIV, MDU_OP_DIVU: begin
                {pend_hi, pend_lo} <= (bus.in_option == MDU_OP_DIV) ? div_s : div_u;
                // Divide by zero still occupies the unit but leaves HI/LO intact.
                pend_wr <= (bus.in_opB != 32'd0);
                cnt     <= MDU_CNT_W'(DIV_CYCLES);
                state   <= ST_DIV;
                busy    <= 1'b1;
              end
              MDU_OP_MTHI: hi <= bus.in_opA;
              MDU_OP_MTLO: lo <= bus.in_opA;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt == MDU_CNT_W'(1)) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            cnt   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - MDU_CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.out = 32'd0;
    if (bus.in_option == MDU_OP_MFHI) begin
      bus.out = hi;
    end else if (bus.in_option == MDU_OP_MFLO) begin
      bus.out = lo;
    end
  end

  assign bus.out_busy = busy;

endmodule
